melody_player: RTL and testbench

- Sequencer that drives the buzzer tone generator's note/enable interface. It plays short fixed tunes (drop, win, error, start) from an internal ROM.
- The game FSM issues a one-cycle play request with a tune select. The player steps through note entries, holding each note code for a timed duration with an articulation gap, then pulses done.
- Sits between game control and the buzzer; its note/note_en outputs connect directly to the buzzer's note/enable inputs.

---
 rtl/melody_player_pkg.sv | 46 ++++
 rtl/melody_rom.sv | 31 +++
 rtl/melody_player.sv | 114 +++++++++++
 tb/tb_melody_player.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/melody_player_pkg.sv
// rtl/melody_player_pkg.sv - note codes, tune indices, ROM layout shared by melody player, buzzer and game FSM
package melody_player_pkg;

  localparam int NOTE_W  = 4;
  localparam int DUR_W   = 3;
  localparam int ENTRY_W = NOTE_W + DUR_W;
  localparam int ADDR_W  = 5;

  localparam logic [NOTE_W-1:0] REST = 4'd0;
  localparam logic [NOTE_W-1:0] C6   = 4'd1;
  localparam logic [NOTE_W-1:0] D6   = 4'd2;
  localparam logic [NOTE_W-1:0] E6   = 4'd3;
  localparam logic [NOTE_W-1:0] F6   = 4'd4;
  localparam logic [NOTE_W-1:0] G6   = 4'd5;
  localparam logic [NOTE_W-1:0] B6   = 4'd6;
  localparam logic [NOTE_W-1:0] C7   = 4'd7;
  localparam logic [NOTE_W-1:0] G5   = 4'd8;
  localparam logic [NOTE_W-1:0] F4   = 4'd9;
  localparam logic [NOTE_W-1:0] B3   = 4'd10;

  localparam logic [1:0] TUNE_DROP  = 2'd0;
  localparam logic [1:0] TUNE_WIN   = 2'd1;
  localparam logic [1:0] TUNE_ERROR = 2'd2;
  localparam logic [1:0] TUNE_START = 2'd3;

  localparam logic [ADDR_W-1:0] BASE_DROP  = 5'd0;
  localparam logic [ADDR_W-1:0] BASE_WIN   = 5'd2;
  localparam logic [ADDR_W-1:0] BASE_ERROR = 5'd7;
  localparam logic [ADDR_W-1:0] BASE_START = 5'd11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PLAY
  } state_t;

  function automatic logic [ADDR_W-1:0] tune_base(input logic [1:0] sel);
    case (sel)
      TUNE_DROP:  tune_base = BASE_DROP;
      TUNE_WIN:   tune_base = BASE_WIN;
      TUNE_ERROR: tune_base = BASE_ERROR;
      default:    tune_base = BASE_START;
    endcase
  endfunction

endpackage

// File: rtl/melody_rom.sv
// rtl/melody_rom.sv - combinational tune ROM, entries are {note, dur}, dur 0 ends a tune
module melody_rom
  import melody_player_pkg::*;
(
  input  logic [ADDR_W-1:0]  addr,
  output logic [ENTRY_W-1:0] entry
);

  always_comb begin
    entry = '0;
    case (addr)
      5'd0:  entry = {G5, 3'd1};
      5'd2:  entry = {C6, 3'd1};
      5'd3:  entry = {E6, 3'd1};
      5'd4:  entry = {G6, 3'd1};
      5'd5:  entry = {C7, 3'd3};
      5'd7:  entry = {F4, 3'd2};
      5'd8:  entry = {REST, 3'd1};
      5'd9:  entry = {B3, 3'd4};
      5'd11: entry = {C6, 3'd1};
      5'd12: entry = {D6, 3'd1};
      5'd13: entry = {E6, 3'd1};
      5'd14: entry = {F6, 3'd1};
      5'd15: entry = {G6, 3'd1};
      5'd16: entry = {B6, 3'd1};
      5'd17: entry = {C7, 3'd2};
      default: entry = '0;
    endcase
  end

endmodule

// File: rtl/melody_player.sv
// rtl/melody_player.sv - steps through a ROM tune, driving buzzer note/enable with timed notes and gaps
module melody_player
  import melody_player_pkg::*;
#(
  parameter int TICK_CLKS  = 390625,
  parameter int UNIT_TICKS = 4,
  parameter int GAP_TICKS  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              play,
  input  logic [1:0]        tune_sel,
  input  logic              stop,
  output logic [NOTE_W-1:0] note,
  output logic              note_en,
  output logic              busy,
  output logic              done
);

  localparam int PW = (TICK_CLKS > 1) ? $clog2(TICK_CLKS) : 1;
  localparam int RW = $clog2(7 * UNIT_TICKS + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_CLKS - 1);

  state_t             state_q, state_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [RW-1:0]      rem_q, rem_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [NOTE_W-1:0]  note_q, note_d;
  logic               done_d;
  logic [ENTRY_W-1:0] entry;
  logic [NOTE_W-1:0]  rom_note;
  logic [DUR_W-1:0]   rom_dur;

  melody_rom u_rom (
    .addr  (addr_q),
    .entry (entry)
  );

  assign {rom_note, rom_dur} = entry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      rem_q   <= '0;
      addr_q  <= '0;
      note_q  <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      note_q  <= note_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    note_d  = note_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        note_d = '0;
        if (play && !stop) begin
          addr_d  = tune_base(tune_sel);
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (stop) begin
          note_d  = '0;
          state_d = ST_IDLE;
        end else if (rom_dur == '0) begin
          note_d  = '0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          note_d  = rom_note;
          rem_d   = RW'(rom_dur) * RW'(UNIT_TICKS);
          presc_d = '0;
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (stop) begin
          note_d  = '0;
          state_d = ST_IDLE;
        end else if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          rem_d   = rem_q - RW'(1);
          if (rem_q == RW'(1)) state_d = ST_FETCH;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: begin
        note_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // The trailing GAP_TICKS of every note are silent so repeated notes articulate.
  assign note_en = (state_q == ST_PLAY) && (note_q != '0) && (rem_q > RW'(GAP_TICKS));
  assign note    = note_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_melody_player.sv
// tb/tb_melody_player.sv - directed self-checking bench for melody_player
module tb_melody_player;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       play;
  logic [1:0] tune_sel;
  logic       stop;
  logic [3:0] note;
  logic       note_en;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;

  int busy_len, done_cnt, zero_cnt, n8_cnt;
  int done_at_fall, end_note, end_en;
  int rise_q[$];
  int run_q[$];

  melody_player #(
    .TICK_CLKS  (4),
    .UNIT_TICKS (4),
    .GAP_TICKS  (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .play     (play),
    .tune_sel (tune_sel),
    .stop     (stop),
    .note     (note),
    .note_en  (note_en),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int rise_at(input int i);
    return (i < rise_q.size()) ? rise_q[i] : -1;
  endfunction

  function automatic int run_at(input int i);
    return (i < run_q.size()) ? run_q[i] : -1;
  endfunction

  task automatic pulse_play(input logic [1:0] sel);
    @(negedge clk);
    play = 1'b1;
    tune_sel = sel;
    @(negedge clk);
    play = 1'b0;
  endtask

  // Follows one tune from its first busy cycle; optionally injects play or stop at a cycle index.
  task automatic trace(input int play_at, input logic [1:0] inj_sel, input int stop_at);
    logic prev_en;
    int run;
    busy_len = 0; done_cnt = 0; zero_cnt = 0; n8_cnt = 0;
    rise_q.delete(); run_q.delete();
    prev_en = 1'b0; run = 0;
    while (busy && busy_len < 1000) begin
      if (note_en && !prev_en) rise_q.push_back(int'(note));
      if (note_en) run++;
      else if (prev_en) begin
        run_q.push_back(run);
        run = 0;
      end
      done_cnt += int'(done);
      if (note == 4'd0) zero_cnt++;
      if (note == 4'd8) n8_cnt++;
      prev_en = note_en;
      play = (busy_len == play_at);
      if (busy_len == play_at) tune_sel = inj_sel;
      stop = (busy_len == stop_at);
      busy_len++;
      @(negedge clk);
    end
    play = 1'b0;
    stop = 1'b0;
    if (prev_en) run_q.push_back(run);
    check("trace_bounded", int'(busy), 0);
    end_note = int'(note);
    end_en = int'(note_en);
    done_at_fall = int'(done);
    done_cnt += int'(done);
    repeat (4) begin
      @(negedge clk);
      done_cnt += int'(done);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; play = 1'b0; stop = 1'b0; tune_sel = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_note", int'(note), 0);
    check("rst_note_en", int'(note_en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset in the middle of tune 3, third note
    pulse_play(2'd3);
    repeat (40) @(negedge clk);
    check("mid_note_before_rst", int'(note), 3);
    check("mid_en_before_rst", int'(note_en), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_note", int'(note), 0);
    check("mid_rst_en", int'(note_en), 0);
    check("mid_rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_play(2'd0);
    trace(-1, 2'd0, -1);
    check("post_rst_busy_len", busy_len, 18);
    check("post_rst_note", rise_at(0), 8);
    check("post_rst_done", done_cnt, 1);

    // Tune 1 full playback
    pulse_play(2'd1);
    trace(-1, 2'd0, -1);
    check("win_busy_len", busy_len, 101);
    check("win_runs", run_q.size(), 4);
    check("win_note0", rise_at(0), 1);
    check("win_note1", rise_at(1), 3);
    check("win_note2", rise_at(2), 5);
    check("win_note3", rise_at(3), 7);
    check("win_en0", run_at(0), 12);
    check("win_en1", run_at(1), 12);
    check("win_en2", run_at(2), 12);
    check("win_en3", run_at(3), 44);
    check("win_done_at_fall", done_at_fall, 1);
    check("win_done_cnt", done_cnt, 1);
    check("win_end_note", end_note, 0);

    // Tune 2 with a rest
    pulse_play(2'd2);
    trace(-1, 2'd0, -1);
    check("err_busy_len", busy_len, 116);
    check("err_runs", run_q.size(), 2);
    check("err_note0", rise_at(0), 9);
    check("err_note1", rise_at(1), 10);
    check("err_en0", run_at(0), 28);
    check("err_en1", run_at(1), 60);
    check("err_zero_cycles", zero_cnt, 18);
    check("err_done_cnt", done_cnt, 1);

    // Stop at cycle 40 of tune 1
    pulse_play(2'd1);
    trace(-1, 2'd0, 40);
    check("stop_busy_len", busy_len, 41);
    check("stop_note", end_note, 0);
    check("stop_en", end_en, 0);
    check("stop_done_cnt", done_cnt, 0);
    check("stop_rises", rise_q.size(), 3);
    check("stop_last_note", rise_at(2), 5);

    // play while busy is ignored
    pulse_play(2'd0);
    trace(10, 2'd3, -1);
    check("ign_busy_len", busy_len, 18);
    check("ign_rises", rise_q.size(), 1);
    check("ign_note", rise_at(0), 8);
    check("ign_en", run_at(0), 12);
    check("ign_n8_cycles", n8_cnt, 17);
    check("ign_done_cnt", done_cnt, 1);
    check("ign_idle_after", int'(busy), 0);

    // play and stop together in IDLE
    @(negedge clk);
    play = 1'b1; stop = 1'b1; tune_sel = 2'd1;
    @(negedge clk);
    play = 1'b0; stop = 1'b0;
    check("ps_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    check("ps_busy_later", int'(busy), 0);
    check("ps_done", int'(done), 0);
    pulse_play(2'd0);
    trace(-1, 2'd0, -1);
    check("ps_retry_busy_len", busy_len, 18);
    check("ps_retry_done", done_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
